apb_to_ahb_bridge: RTL and testbench
====================================

Name: apb_to_ahb_bridge

Overview:
- Reverse of the existing AHB-to-APB path: an APB completer (slave) on the peripheral side and an AHB-Lite manager (master) on the system side.
- Lets an APB-side agent (debug port, DMA config engine) issue single-word reads and writes into AHB memory space.
- Exactly one AHB transfer per APB access; no bursts, no outstanding transfers.
- Single clock domain; APB and AHB both run on HCLK.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and HADDR.
- DATA_WIDTH, 32, width of all data buses; must be 32 or 64. HSIZE = log2(DATA_WIDTH/8).

Ports:
- HCLK  in  1  bridge clock; also the APB clock.
- HRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access-phase flag.
- PADDR  in  ADDR_WIDTH  APB address.
- PWRITE  in  1  1 = write.
- PWDATA  in  DATA_WIDTH  APB write data.
- PRDATA  out  DATA_WIDTH  read data returned to APB.
- PREADY  out  1  APB access completion.
- PSLVERR  out  1  error flag, valid only while PREADY=1.
- HADDR  out  ADDR_WIDTH  AHB address.
- HTRANS  out  2  IDLE or NONSEQ only.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  constant word size.
- HBURST  out  3  constant SINGLE (3'b000).
- HWDATA  out  DATA_WIDTH  AHB write data.
- HRDATA  in  DATA_WIDTH  AHB read data.
- HREADY  in  1  AHB bus ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- All outputs are registered.
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, PRDATA=0, PREADY=0, PSLVERR=0, FSM in IDLE.
- Reset mid-transfer aborts immediately; HTRANS returns to IDLE asynchronously.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On a posedge with PSEL=1 and PENABLE=0 (APB setup phase), latch PADDR, PWRITE and PWDATA.
  - Drive HADDR, HWRITE and HTRANS=NONSEQ; go to ADDR.
- ADDR:
  - Hold HTRANS, HADDR and HWRITE stable until HREADY=1 is sampled.
  - On that edge: HTRANS becomes IDLE, HWDATA takes the latched write data, go to DATA.
- DATA:
  - Wait for HREADY=1.
  - On that edge: if the transfer is a read, PRDATA takes HRDATA; PSLVERR takes HRESP; PREADY becomes 1; go to DONE.
  - PRDATA is unchanged on writes.
  - The first ERROR cycle (HRESP=1, HREADY=0) is simply waited through, since HTRANS is already IDLE. The error is captured on the second cycle.
- DONE:
  - PREADY=1 for exactly one cycle. On the next edge PREADY and PSLVERR clear and the FSM goes to IDLE.
  - HWDATA holds its value until the next transfer.
- Latency:
  - With a zero-wait AHB slave, PREADY is high in the 4th APB cycle counted from setup (setup + 2 wait states + completing access cycle).
  - Each AHB wait state adds 1 cycle.
- Back-to-back accesses: a new setup phase in the cycle after DONE is accepted from IDLE with no bubble.
- Protocol violations:
  - PSEL or PENABLE dropping mid-transfer: the AHB transfer still completes, and DONE still pulses PREADY for one cycle.
  - PENABLE=1 seen while in IDLE: ignored; no AHB transfer is started.
- HSIZE and HBURST are constants. HADDR is PADDR passed through unmodified; alignment is the requester's responsibility.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HBURST_SINGLE=3'b000.
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
  - HSIZE codes: BYTE=0, HALF=1, WORD=2, DWORD=3.
- The FSM state enum stays local to the module.
- No sub-module: the block is a single FSM plus capture registers.

Test Plan:
- Write PADDR=0x04, PWDATA=0xBEEF_BEEF to a zero-wait AHB memory model -> HTRANS=NONSEQ for 1 cycle with HADDR=0x04, HWRITE=1; HWDATA=0xBEEF_BEEF in the next cycle; PREADY=1 in the 4th cycle; PSLVERR=0; memory[0x04]=0xBEEF_BEEF.
- Read of 0x04 after the above -> PRDATA=0xBEEF_BEEF when PREADY=1.
- AHB slave inserts 3 wait states on the address phase and 2 on the data phase -> HADDR/HTRANS held stable throughout; PREADY in cycle 9; write of 0xDEAD_BEEF to 0x08 lands correctly.
- Two-cycle ERROR response on a read of 0xFC -> PSLVERR=1 and PREADY=1 in the same cycle; PRDATA updated with the bus value; next access to 0x0C completes with PSLVERR=0.
- Four back-to-back writes to 0x20..0x2C (0x1000_0000+i), then four reads -> no idle cycle between accesses; all read data matches.
- HRESET asserted while in DATA with HREADY=0 -> HTRANS=IDLE, PREADY=0, PRDATA=0 immediately; after release, a write of 0xCAFE_BEEF to 0x50 completes normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the bridge and its environment.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Transfer size code for a full-width bus beat (32 or 64 bits).
  function automatic logic [2:0] hsize_for(input int unsigned data_width);
    return (data_width == 64) ? HSIZE_DWORD : HSIZE_WORD;
  endfunction

endpackage

// File: rtl/apb_to_ahb_bridge_if.sv
// APB completer + AHB-Lite manager signal bundle seen by the bridge.
// slave  : the bridge (APB completer, drives the AHB manager outputs)
// master : the surrounding system (APB requester and AHB subordinate)
interface apb_to_ahb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, HRDATA, HREADY, HRESP,
    output PRDATA, PREADY, PSLVERR, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, HRDATA, HREADY, HRESP,
    input  PRDATA, PREADY, PSLVERR, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/apb_to_ahb_bridge.sv
// APB completer that turns each APB access into one single-beat AHB-Lite
// transfer. One FSM plus capture registers; every output is a flop.
module apb_to_ahb_bridge
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                HCLK,
  input logic                HRESET,
  apb_to_ahb_bridge_if.slave bus
);

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("apb_to_ahb_bridge: DATA_WIDTH must be 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;    // PWDATA captured at setup
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  // Next-state and next-output decode; APB handshake is only looked at in
  // IDLE, so a requester that drops PSEL/PENABLE mid-access cannot stall
  // or truncate an AHB transfer already in flight.
  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    htrans_d  = htrans_q;
    wdata_d   = wdata_q;
    hwdata_d  = hwdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          haddr_d  = bus.PADDR;
          hwrite_d = bus.PWRITE;
          wdata_d  = bus.PWDATA;
          htrans_d = HTRANS_NONSEQ;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.HREADY) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        // First cycle of a two-cycle ERROR has HREADY=0 and is just waited out.
        if (bus.HREADY) begin
          if (!hwrite_q) prdata_d = bus.HRDATA;
          pslverr_d = bus.HRESP;
          pready_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      wdata_q   <= '0;
      hwdata_q  <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      htrans_q  <= htrans_d;
      wdata_q   <= wdata_d;
      hwdata_q  <= hwdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign bus.HADDR   = haddr_q;
  assign bus.HWRITE  = hwrite_q;
  assign bus.HTRANS  = htrans_q;
  assign bus.HWDATA  = hwdata_q;
  assign bus.HSIZE   = hsize_for(DATA_WIDTH);
  assign bus.HBURST  = HBURST_SINGLE;
  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Scoreboard bench: APB requester pushes expected responses, an AHB memory
// slave with programmable wait/error behaviour services the bus, and a
// monitor pops and compares whenever PREADY is presented.
module tb_apb_to_ahb_bridge;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  apb_to_ahb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_to_ahb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    bit          err;
    logic [31:0] exp_prdata;
    int          setup_cyc;
  } txn_t;

  txn_t cfg_q[$];   // consumed by the AHB slave model
  txn_t exp_q[$];   // consumed by the PREADY monitor

  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];
  logic [31:0] last_prdata = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] err_val(input logic [31:0] a);
    return 32'hE000_0000 | a;
  endfunction

  // Reference model: 0xF0..0xFF is an erroring region; errored writes do
  // not land, errored reads return whatever the bus shows.
  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int aw, input int dw, input bit drop);
    txn_t e;
    int   n;
    e.w = w; e.addr = a; e.wdata = d; e.aw = aw; e.dw = dw;
    e.err = (a[31:4] == 28'h000000F);
    if (w) begin
      if (!e.err) ref_mem[a] = d;
      e.exp_prdata = last_prdata;
    end else begin
      e.exp_prdata = e.err ? err_val(a) : (ref_mem.exists(a) ? ref_mem[a] : 32'h0);
      last_prdata  = e.exp_prdata;
    end
    e.setup_cyc = cyc;
    cfg_q.push_back(e);
    exp_q.push_back(e);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = d;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    if (drop) begin bus.PSEL = 1'b0; bus.PENABLE = 1'b0; end
    n = 0;
    while (!bus.PREADY && n < 100) begin @(posedge HCLK); #1; n++; end
    if (n >= 100) chk("pready_timeout", 64'(n), 64'(0));
    @(posedge HCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // ---------------- AHB slave model ----------------
  typedef enum {P_IDLE, P_ADDR, P_DFIRST, P_DATA} sph_e;
  sph_e        ph;
  txn_t        cur;
  int          cnt;
  bit          estage;
  logic [31:0] s_addr;

  task automatic addr_step();
    chk("htrans_nonseq", 64'(bus.HTRANS), 64'(HTRANS_NONSEQ));
    chk("haddr", 64'(bus.HADDR), 64'(cur.addr));
    chk("hwrite", 64'(bus.HWRITE), 64'(cur.w));
    if (cnt == 0) begin bus.HREADY = 1'b1; ph = P_DFIRST; end
    else begin bus.HREADY = 1'b0; cnt--; end
  endtask

  task automatic data_step();
    if (cnt > 0) begin
      bus.HREADY = 1'b0; bus.HRESP = 1'b0; cnt--;
    end else if (cur.err && !estage) begin
      bus.HREADY = 1'b0; bus.HRESP = 1'b1; bus.HRDATA = err_val(s_addr); estage = 1'b1;
    end else begin
      bus.HREADY = 1'b1;
      bus.HRESP  = cur.err;
      if (cur.err) bus.HRDATA = err_val(s_addr);
      else bus.HRDATA = smem.exists(s_addr) ? smem[s_addr] : 32'h0;
      if (cur.w && !cur.err) smem[s_addr] = bus.HWDATA;
      ph = P_IDLE;
    end
  endtask

  initial begin
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    ph = P_IDLE; cnt = 0; estage = 1'b0; s_addr = '0;
    cur = '{w: 1'b0, addr: '0, wdata: '0, aw: 0, dw: 0, err: 1'b0, exp_prdata: '0, setup_cyc: 0};
    forever begin
      @(posedge HCLK); #1;
      if (HRESET) begin
        ph = P_IDLE; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end else begin
        case (ph)
          P_IDLE: begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b0;
            if (bus.HTRANS == HTRANS_NONSEQ) begin
              if (cfg_q.size() == 0) begin
                chk("spurious_nonseq", 64'(bus.HTRANS), 64'(HTRANS_IDLE));
                cur = '{w: bus.HWRITE, addr: bus.HADDR, wdata: '0, aw: 0, dw: 0,
                        err: 1'b0, exp_prdata: '0, setup_cyc: 0};
              end else cur = cfg_q.pop_front();
              s_addr = bus.HADDR; cnt = cur.aw; ph = P_ADDR;
              addr_step();
            end
          end
          P_ADDR: addr_step();
          P_DFIRST: begin
            chk("htrans_idle_in_data", 64'(bus.HTRANS), 64'(HTRANS_IDLE));
            if (cur.w) chk("hwdata", 64'(bus.HWDATA), 64'(cur.wdata));
            cnt = cur.dw; estage = 1'b0; ph = P_DATA;
            data_step();
          end
          P_DATA: data_step();
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    txn_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESET && bus.PREADY) begin
        if (exp_q.size() == 0) chk("unexpected_pready", 64'(bus.PREADY), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("pslverr", 64'(bus.PSLVERR), 64'(e.err));
          chk("prdata", 64'(bus.PRDATA), 64'(e.exp_prdata));
          chk("latency", 64'(cyc - e.setup_cyc), 64'(3 + e.aw + e.dw + int'(e.err)));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int n;
    HRESET = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = '0; bus.PWRITE = 1'b0; bus.PWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_htrans", 64'(bus.HTRANS), 64'(HTRANS_IDLE));
    chk("rst_haddr", 64'(bus.HADDR), 64'(0));
    chk("rst_hwrite", 64'(bus.HWRITE), 64'(0));
    chk("rst_hwdata", 64'(bus.HWDATA), 64'(0));
    chk("rst_prdata", 64'(bus.PRDATA), 64'(0));
    chk("rst_pready", 64'(bus.PREADY), 64'(0));
    chk("rst_pslverr", 64'(bus.PSLVERR), 64'(0));
    chk("hsize", 64'(bus.HSIZE), 64'(HSIZE_WORD));
    chk("hburst", 64'(bus.HBURST), 64'(HBURST_SINGLE));
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // PENABLE high while idle must not start a transfer
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PADDR = 32'h40; bus.PWRITE = 1'b1;
    repeat (3) begin @(posedge HCLK); #1; chk("penable_idle_htrans", 64'(bus.HTRANS), 64'(HTRANS_IDLE)); end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(posedge HCLK); #1;

    // directed cases
    apb_xfer(1'b1, 32'h04, 32'hBEEF_BEEF, 0, 0, 1'b0);
    chk("mem_04", 64'(smem.exists(32'h04) ? smem[32'h04] : 32'h0), 64'(32'hBEEF_BEEF));
    apb_xfer(1'b0, 32'h04, 32'h0, 0, 0, 1'b0);
    apb_xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 3, 2, 1'b0);
    apb_xfer(1'b0, 32'h08, 32'h0, 0, 0, 1'b0);
    apb_xfer(1'b0, 32'hFC, 32'h0, 0, 0, 1'b0);
    apb_xfer(1'b1, 32'h0C, 32'h1234_5678, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) apb_xfer(1'b1, 32'h20 + 32'(4 * i), 32'h1000_0000 + 32'(i), 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) apb_xfer(1'b0, 32'h20 + 32'(4 * i), 32'h0, 0, 0, 1'b0);
    apb_xfer(1'b1, 32'h30, 32'h5A5A_0001, 1, 1, 1'b1);   // PSEL dropped mid-access
    apb_xfer(1'b0, 32'h30, 32'h0, 2, 0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    // reset while waiting in the data phase
    apb_xfer(1'b0, 32'h04, 32'h0, 0, 0, 1'b0);
    cfg_q.push_back('{w: 1'b1, addr: 32'h60, wdata: 32'h1357_2468, aw: 0, dw: 20,
                      err: 1'b0, exp_prdata: '0, setup_cyc: cyc});
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 32'h60; bus.PWRITE = 1'b1; bus.PWDATA = 32'h1357_2468;
    @(posedge HCLK); #1;
    bus.PENABLE = 1'b1;
    repeat (3) @(posedge HCLK);
    #2;
    HRESET = 1'b1;
    #1;
    chk("midrst_htrans", 64'(bus.HTRANS), 64'(HTRANS_IDLE));
    chk("midrst_pready", 64'(bus.PREADY), 64'(0));
    chk("midrst_prdata", 64'(bus.PRDATA), 64'(0));
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    last_prdata = '0;
    @(posedge HCLK); #3;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    chk("mem_60_untouched", 64'(smem.exists(32'h60)), 64'(ref_mem.exists(32'h60)));
    apb_xfer(1'b1, 32'h50, 32'hCAFE_BEEF, 0, 0, 1'b0);
    apb_xfer(1'b0, 32'h50, 32'h0, 1, 1, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge HCLK); n++; end
    repeat (3) @(posedge HCLK);
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("cfg_q_drained", 64'(cfg_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
